// File: rtl/mips_bus_master.sv
// mips_bus_master: CPU-side initiator for a byte-addressed, little-endian,
// Avalon-style data bus. It takes one load/store request at a time, handles
// word alignment, byteenable lane selection and waitrequest stalls. Loads are
// returned sign- or zero-extended. Misaligned or reserved-size requests are
// rejected without bus traffic.
// Optional feature macro: MIPS_BUS_TIMEOUT_EN (stall timeout abort after
// TIMEOUT_CYCLES waitrequest cycles).
module mips_bus_master #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {IDLE, BUS, RDATA, RESP} state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_write_op;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic        r_read;
  logic        r_write;
  logic [31:0] r_address;
  logic [3:0]  r_byteenable;
  logic [31:0] r_writedata;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  logic        w_bad;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_sh;
  logic [31:0] w_rdata_sh;
  logic [31:0] w_rdata_ext;
  logic        w_timeout;

  // A zero timeout would abort before the first stall could be counted.
  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef MIPS_BUS_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] r_stall;

  // Stall counter: zero outside BUS, counts waitrequest cycles inside BUS.
  always_ff @(posedge clk) begin
    if (reset || r_state != BUS) begin
      r_stall <= '0;
    end else if (waitrequest) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  // Abort on the edge that completes the TIMEOUT_CYCLES-th stall cycle.
  assign w_timeout = (r_state == BUS) && waitrequest &&
                     (r_stall == CW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Request decode: alignment check, lane mask and lane-shifted store data.
  always_comb begin
    w_bad      = 1'b0;
    w_be       = 4'b1111;
    w_wdata_sh = req_wdata;
    case (req_size)
      2'b00: begin
        w_be       = 4'b0001 << req_addr[1:0];
        w_wdata_sh = {24'b0, req_wdata[7:0]} << {req_addr[1:0], 3'b000};
      end
      2'b01: begin
        w_bad      = req_addr[0];
        w_be       = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_sh = {16'b0, req_wdata[15:0]} << {req_addr[1], 4'b0000};
      end
      2'b10: begin
        w_bad      = |req_addr[1:0];
      end
      default: begin
        w_bad      = 1'b1;
      end
    endcase
  end

  // Load path: bring the addressed lane down to bit 0, then extend it.
  always_comb begin
    w_rdata_sh  = readdata >> {r_lane, 3'b000};
    w_rdata_ext = w_rdata_sh;
    case (r_size)
      2'b00:   w_rdata_ext = {{24{r_signed & w_rdata_sh[7]}}, w_rdata_sh[7:0]};
      2'b01:   w_rdata_ext = {{16{r_signed & w_rdata_sh[15]}}, w_rdata_sh[15:0]};
      default: w_rdata_ext = w_rdata_sh;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_next = w_bad ? RESP : BUS;
      BUS: begin
        if (w_timeout)         w_state_next = RESP;
        else if (!waitrequest) w_state_next = r_write_op ? RESP : RDATA;
      end
      RDATA:   w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Bus outputs and response data; strobes drop on the completing edge while
  // address/lanes/data simply stay at their last values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write_op   <= 1'b0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_lane       <= 2'b00;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_address    <= '0;
      r_byteenable <= '0;
      r_writedata  <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            if (w_bad) begin
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_write_op   <= req_write;
              r_size       <= req_size;
              r_signed     <= req_signed;
              r_lane       <= req_addr[1:0];
              r_read       <= ~req_write;
              r_write      <= req_write;
              r_address    <= {req_addr[31:2], 2'b00};
              r_byteenable <= w_be;
              r_writedata  <= w_wdata_sh;
            end
          end
        end
        BUS: begin
          if (w_timeout) begin
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
          end else if (!waitrequest) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            if (r_write_op) begin
              r_resp_err   <= 1'b0;
              r_resp_rdata <= '0;
            end
          end
        end
        RDATA: begin
          r_resp_rdata <= w_rdata_ext;
          r_resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign address    = r_address;
  assign read       = r_read;
  assign write      = r_write;
  assign byteenable = r_byteenable;
  assign writedata  = r_writedata;

endmodule

// File: tb/tb_mips_bus_master.sv
// Testbench for mips_bus_master: a byte-array slave with programmable
// waitrequest stalls, and a scoreboard of expected responses.
// Define MIPS_BUS_TIMEOUT_EN to also exercise the stall timeout (4 cycles).
module tb_mips_bus_master;

`ifdef MIPS_BUS_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 64;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mips_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  // Slave model: 256-byte memory, readdata one cycle after an accepted read.
  logic [7:0] mem [0:255];
  int wait_cfg = 0;
  int stall_cnt = 0;
  assign waitrequest = (read || write) && (stall_cnt < wait_cfg);

  always @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 0;
      readdata  <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[4] <= 8'h21; mem[5] <= 8'h43; mem[6] <= 8'h65; mem[7] <= 8'h87;
    end else if (!(read || write)) begin
      stall_cnt <= 0;
    end else if (waitrequest) begin
      stall_cnt <= stall_cnt + 1;
    end else begin
      stall_cnt <= 0;
      if (write)
        for (int i = 0; i < 4; i++)
          if (byteenable[i]) mem[{address[7:2], 2'(i)}] <= writedata[8*i +: 8];
      if (read)
        readdata <= {mem[{address[7:2], 2'd3}], mem[{address[7:2], 2'd2}],
                     mem[{address[7:2], 2'd1}], mem[{address[7:2], 2'd0}]};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transaction; entered and left on a negedge.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int waits,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int exp_strobes,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd);
    int lat;
    int strobes;
    bit got;
    bit first;
    exp_t e;
    wait_cfg = waits;
    sb.push_back('{exp_rd, exp_err, exp_lat});
    check("ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; strobes = 0; got = 1'b0; first = 1'b1;
    while (!got && lat < 200) begin
      if (read || write) begin
        strobes++;
        check("bus_address", address, exp_addr);
        check("bus_be", {28'b0, byteenable}, {28'b0, exp_be});
        if (first) begin
          check("bus_read", {31'b0, read}, {31'b0, ~wr});
          check("bus_write", {31'b0, write}, {31'b0, wr});
          if (wr) check("bus_wdata", writedata, exp_wd);
          first = 1'b0;
        end
      end
      if (resp_valid) begin
        got = 1'b1;
        check("sb_nonempty", sb.size(), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("resp_rdata", resp_rdata, e.rd);
          check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
          check("resp_latency", lat, e.lat);
        end
        check("ready_in_resp", {31'b0, req_ready}, 32'd0);
      end else begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
    end
    if (!got) check("resp_seen", 32'd0, 32'd1);
    check("strobe_cycles", strobes, exp_strobes);
    $display("txn wr=%0d size=%0d signed=%0d addr=0x%08h waits=%0d -> rdata=0x%08h err=%0d lat=%0d",
             wr, sz, sg, a, waits, resp_rdata, resp_err, lat);
    @(posedge clk);
    @(negedge clk);
    check("resp_pulse", {31'b0, resp_valid}, 32'd0);
    check("rdata_hold", resp_rdata, exp_rd);
    check("err_hold", {31'b0, resp_err}, {31'b0, exp_err});
  endtask

  initial begin
    int seen;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_rw", {30'b0, read, write}, 32'd0);
    check("rst_address", address, 32'd0);
    check("rst_be", {28'b0, byteenable}, 32'd0);
    check("rst_wdata", writedata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    //      wr sz    sg addr           wdata          waits exp_rd        err lat str addr          be       wd
    do_req(1, 2'b10, 0, 32'h0000_0010, 32'hDEADBEEF, 0, 32'h0000_0000, 0, 1, 1, 32'h10, 4'b1111, 32'hDEADBEEF);
    do_req(0, 2'b00, 1, 32'h0000_0013, 32'h0,        0, 32'hFFFF_FFDE, 0, 2, 1, 32'h10, 4'b1000, 32'h0);
    do_req(0, 2'b00, 0, 32'h0000_0013, 32'h0,        0, 32'h0000_00DE, 0, 2, 1, 32'h10, 4'b1000, 32'h0);
    do_req(0, 2'b01, 1, 32'h0000_0012, 32'h0,        0, 32'hFFFF_DEAD, 0, 2, 1, 32'h10, 4'b1100, 32'h0);
    do_req(0, 2'b01, 0, 32'h0000_0010, 32'h0,        0, 32'h0000_BEEF, 0, 2, 1, 32'h10, 4'b0011, 32'h0);
    do_req(0, 2'b00, 1, 32'h0000_0010, 32'h0,        0, 32'hFFFF_FFEF, 0, 2, 1, 32'h10, 4'b0001, 32'h0);
    do_req(1, 2'b00, 0, 32'h0000_0011, 32'hFFFFFF5A, 0, 32'h0000_0000, 0, 1, 1, 32'h10, 4'b0010, 32'h00005A00);
    do_req(0, 2'b10, 0, 32'h0000_0010, 32'h0,        0, 32'hDEAD_5AEF, 0, 2, 1, 32'h10, 4'b1111, 32'h0);
    do_req(1, 2'b01, 0, 32'h0000_0016, 32'hABCD1234, 0, 32'h0000_0000, 0, 1, 1, 32'h14, 4'b1100, 32'h12340000);
    do_req(0, 2'b01, 1, 32'h0000_0016, 32'h0,        0, 32'h0000_1234, 0, 2, 1, 32'h14, 4'b1100, 32'h0);
    do_req(0, 2'b10, 0, 32'h0000_0014, 32'h0,        0, 32'h1234_0000, 0, 2, 1, 32'h14, 4'b1111, 32'h0);
    do_req(0, 2'b10, 0, 32'hBFC0_0004, 32'h0,        3, 32'h8765_4321, 0, 5, 4, 32'hBFC00004, 4'b1111, 32'h0);
    do_req(1, 2'b00, 0, 32'h0000_0003, 32'h00000080, 2, 32'h0000_0000, 0, 3, 3, 32'h00, 4'b1000, 32'h80000000);
    do_req(0, 2'b00, 1, 32'h0000_0003, 32'h0,        0, 32'hFFFF_FF80, 0, 2, 1, 32'h00, 4'b1000, 32'h0);
    do_req(0, 2'b01, 0, 32'h0000_0002, 32'h0,        0, 32'h0000_8000, 0, 2, 1, 32'h00, 4'b1100, 32'h0);
    // Rejected requests: no strobes, error response right after accept.
    do_req(0, 2'b10, 0, 32'h0000_0002, 32'h0,        0, 32'h0000_0000, 1, 0, 0, 32'h0, 4'b0000, 32'h0);
    do_req(0, 2'b01, 1, 32'h0000_0001, 32'h0,        0, 32'h0000_0000, 1, 0, 0, 32'h0, 4'b0000, 32'h0);
    do_req(1, 2'b10, 0, 32'h0000_0005, 32'h12345678, 0, 32'h0000_0000, 1, 0, 0, 32'h0, 4'b0000, 32'h0);
    do_req(0, 2'b11, 0, 32'h0000_0010, 32'h0,        0, 32'h0000_0000, 1, 0, 0, 32'h0, 4'b0000, 32'h0);
    // A good response after an error clears resp_err.
    do_req(0, 2'b10, 0, 32'h0000_0010, 32'h0,        0, 32'hDEAD_5AEF, 0, 2, 1, 32'h10, 4'b1111, 32'h0);
`ifdef MIPS_BUS_TIMEOUT_EN
    do_req(0, 2'b10, 0, 32'h0000_0010, 32'h0,     1000, 32'h0000_0000, 1, 4, 4, 32'h10, 4'b1111, 32'h0);
    do_req(1, 2'b10, 0, 32'h0000_0010, 32'h1,     1000, 32'h0000_0000, 1, 4, 4, 32'h10, 4'b1111, 32'h1);
`endif

    // Reset in the middle of a stalled read: strobe drops, no response.
    wait_cfg = 5;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("midbus_read", {31'b0, read}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_read_drop", {31'b0, read}, 32'd0);
    check("reset_ready", {31'b0, req_ready}, 32'd1);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid || read) seen++;
    end
    check("no_resp_after_reset", seen, 32'd0);
    $display("txn reset mid-BUS -> read=%0d resp_events=%0d", read, seen);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips_bus_master.md
Name: mips_bus_master

Overview:
- CPU-side initiator for the byte-addressed, little-endian, Avalon-style data bus served by the team's memory model.
- Takes one load/store request at a time from the core and handles word alignment, byteenable lane selection and waitrequest stalls.
- On loads, extracts the addressed lane and sign/zero-extends it, then returns a single-cycle response.
- Misaligned accesses are rejected without any bus traffic.

Parameters:
TIMEOUT_CYCLES, 64, stall cycles tolerated before abort; used only when MIPS_BUS_TIMEOUT_EN is defined.

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-high reset
req_valid  input  1  core request present
req_ready  output  1  high only in IDLE; request accepted at edge where req_valid&req_ready
req_write  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_signed  input  1  loads: sign-extend (1) / zero-extend (0)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  extended load data; 0 for stores/errors
resp_err  output  1  misaligned/reserved (or timeout), valid with resp_valid
address  output  32  bus word address {addr[31:2],2'b00}
read  output  1  bus read strobe
write  output  1  bus write strobe
byteenable  output  4  active lanes
writedata  output  32  lane-shifted store data
waitrequest  input  1  slave stall
readdata  input  32  slave data, registered one cycle after accepted read

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; read=0, write=0, address=0, byteenable=0, writedata=0.
- States: IDLE, BUS, RDATA, RESP.
- IDLE, on accept (edge E0):
  - Aligned: latch request, drive bus outputs, go BUS.
  - Misaligned (half with a[0]=1, word with a[1:0]!=0) or size=11: go RESP with err=1; read/write stay 0.
- Lane rules, k=a[1:0]:
  - Byte: byteenable=1<<k; writedata=wdata[7:0]<<8k.
  - Half: byteenable=a[1]?1100:0011; writedata=wdata[15:0]<<16*a[1].
  - Word: byteenable=1111; writedata=wdata.
- BUS:
  - Strobe, address, byteenable and writedata held stable while waitrequest=1.
  - At first edge with waitrequest=0: write -> RESP; read -> RDATA. Strobes drop at that edge.
- RDATA: at next edge, capture readdata lane (same shift as writes), extend per size/req_signed into resp_rdata, go RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE; req_ready=0 in BUS/RDATA/RESP.
- Latency, accept edge E0 to resp_valid cycle, zero wait:
  - Store: resp_valid after E1.
  - Load: resp_valid after E2.
  - Error: resp_valid after E0.
  - Each waitrequest cycle adds one.
- resp_rdata/resp_err hold their last values until the next response.
- Reset mid-transaction: at the reset edge, go IDLE and drop strobes the same edge; no response is issued for the aborted request.
- A new req_valid during RESP is not accepted until IDLE, so back-to-back accepts are ≥1 idle cycle apart.

Optional Feature:
MIPS_BUS_TIMEOUT_EN:
- Defined: an 8+ bit stall counter clears on entering BUS and increments each cycle waitrequest=1. On reaching TIMEOUT_CYCLES, drop strobes, go RESP with resp_err=1, resp_rdata=0.
- Undefined: no counter; BUS waits indefinitely.

Test Plan:
- Store word 0xDEADBEEF @0x10 -> write=1, address=0x10, byteenable=1111, writedata=0xDEADBEEF; resp_valid 2 cycles after accept, resp_err=0.
- Then load byte signed @0x13 -> resp_rdata=0xFFFFFFDE; unsigned -> 0x000000DE; half signed @0x12 -> 0xFFFFDEAD; each resp 3 cycles after accept.
- Store byte 0x5A @0x11 -> byteenable=0010, writedata=0x00005A00, address=0x10; word readback @0x10 = 0xDEAD5AEF.
- Load word @0xBFC00004 with waitrequest high 3 cycles -> strobe/address stable throughout, resp 6 cycles after accept.
- Load word @0x02 and half @0x01 -> resp_err=1 one cycle after accept; read never asserted. Reset asserted mid-BUS -> read=0 next cycle, no resp_valid.
- With MIPS_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, waitrequest stuck high -> strobe drops after 4 stall cycles, resp_err=1.
